// File: rtl/serial_deserializer.sv
// Serial-to-parallel deserializer: shifts a 1-bit stream into WIDTH-bit words
// under valid/ready, with an output register plus one held word behind it.
module serial_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     ser_in,
  input  logic                     ser_valid,
  output logic                     ser_ready,
  output logic [WIDTH-1:0]         par_out,
  output logic                     par_valid,
  input  logic                     par_ready,
  output logic [$clog2(WIDTH)-1:0] bit_cnt
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {SHIFT, FULL} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shift, w_shift_nxt;
  logic [CW-1:0]    r_cnt,   w_cnt_nxt;
  logic [WIDTH-1:0] r_par,   w_par_nxt;
  logic             r_pval,  w_pval_nxt;

  logic             w_accept;
  logic             w_pop;
  logic             w_last;
  logic [WIDTH-1:0] w_shifted;

  assign ser_ready = reset & (r_state != FULL);
  assign w_accept  = ser_valid & ser_ready;
  assign w_pop     = r_pval & par_ready;
  assign w_last    = (r_cnt == CW'(WIDTH - 1));
  assign w_shifted = MSB_FIRST ? {r_shift[WIDTH-2:0], ser_in}
                               : {ser_in, r_shift[WIDTH-1:1]};

  assign par_out   = r_par;
  assign par_valid = r_pval;
  assign bit_cnt   = r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= SHIFT;
      r_shift <= '0;
      r_cnt   <= '0;
      r_par   <= '0;
      r_pval  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
      r_par   <= w_par_nxt;
      r_pval  <= w_pval_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_par_nxt   = r_par;
    w_pval_nxt  = r_pval;

    // A pop empties the slot unless a word is loaded into it below.
    if (w_pop) begin
      w_pval_nxt = 1'b0;
    end

    if (clr) begin
      w_shift_nxt = '0;
      w_cnt_nxt   = '0;
      w_state_nxt = SHIFT;
    end else begin
      case (r_state)
        SHIFT: begin
          if (w_accept) begin
            w_shift_nxt = w_shifted;
            if (!w_last) begin
              w_cnt_nxt = r_cnt + 1'b1;
            end else begin
              w_cnt_nxt = '0;
              if (!r_pval || w_pop) begin
                w_par_nxt  = w_shifted;
                w_pval_nxt = 1'b1;
              end else begin
                w_state_nxt = FULL;
              end
            end
          end
        end
        FULL: begin
          if (w_pop) begin
            w_par_nxt   = r_shift;
            w_pval_nxt  = 1'b1;
            w_state_nxt = SHIFT;
          end
        end
        default: w_state_nxt = SHIFT;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_deserializer.sv
// Directed bench for serial_deserializer: one MSB-first and one LSB-first
// instance share the same stimulus; expected words are hand-computed constants.
module tb_serial_deserializer;

  logic       clk;
  logic       reset;
  logic       clr;
  logic       ser_in;
  logic       ser_valid;
  logic       par_ready;

  logic       m_ready, l_ready;
  logic [7:0] m_out,   l_out;
  logic       m_valid, l_valid;
  logic [2:0] m_cnt,   l_cnt;

  int unsigned n_vec;
  int unsigned n_err;

  serial_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .clr(clr), .ser_in(ser_in), .ser_valid(ser_valid),
    .ser_ready(m_ready), .par_out(m_out), .par_valid(m_valid),
    .par_ready(par_ready), .bit_cnt(m_cnt)
  );

  serial_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .clr(clr), .ser_in(ser_in), .ser_valid(ser_valid),
    .ser_ready(l_ready), .par_out(l_out), .par_valid(l_valid),
    .par_ready(par_ready), .bit_cnt(l_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the bit's accepting edge.
  task automatic send_bit(input logic b);
    ser_in    = b;
    ser_valid = 1'b1;
    @(negedge clk);
    ser_valid = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    reset     = 1'b0;
    clr       = 1'b0;
    ser_in    = 1'b0;
    ser_valid = 1'b0;
    par_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check_val("rst_m_valid", 32'(m_valid), 32'd0);
    check_val("rst_m_out",   32'(m_out),   32'h00);
    check_val("rst_m_cnt",   32'(m_cnt),   32'd0);
    check_val("rst_m_ready", 32'(m_ready), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check_val("rel_m_ready", 32'(m_ready), 32'd1);
    check_val("rel_l_ready", 32'(l_ready), 32'd1);

    // A5 with consumer always ready: valid for exactly one cycle
    par_ready = 1'b1;
    send_word(8'hA5);
    check_val("a5_m_out",   32'(m_out),   32'hA5);
    check_val("a5_m_valid", 32'(m_valid), 32'd1);
    check_val("a5_l_out",   32'(l_out),   32'hA5);
    check_val("a5_m_cnt",   32'(m_cnt),   32'd0);
    @(negedge clk);
    check_val("a5_m_drop",  32'(m_valid), 32'd0);
    check_val("a5_m_keep",  32'(m_out),   32'hA5);

    // Bit order: 1,1,0,0,0,0,0,0
    send_word(8'hC0);
    check_val("c0_m_out", 32'(m_out), 32'hC0);
    check_val("c0_l_out", 32'(l_out), 32'h03);
    @(negedge clk);

    // Reset mid-word with a word sitting in the output register
    par_ready = 1'b0;
    send_word(8'h96);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    check_val("mid_m_cnt",   32'(m_cnt),   32'd3);
    check_val("mid_m_valid", 32'(m_valid), 32'd1);
    #1 reset = 1'b0;
    #1;
    check_val("arst_m_valid", 32'(m_valid), 32'd0);
    check_val("arst_m_out",   32'(m_out),   32'h00);
    check_val("arst_m_cnt",   32'(m_cnt),   32'd0);
    check_val("arst_m_ready", 32'(m_ready), 32'd0);
    check_val("arst_l_out",   32'(l_out),   32'h00);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_val("arel_m_ready", 32'(m_ready), 32'd1);
    check_val("arel_m_cnt",   32'(m_cnt),   32'd0);

    // Two words with no consumer: second held, serial side stalls
    send_word(8'h3C);
    check_val("w1_m_out",   32'(m_out),   32'h3C);
    check_val("w1_m_ready", 32'(m_ready), 32'd1);
    send_word(8'h81);
    check_val("full_m_out",   32'(m_out),   32'h3C);
    check_val("full_m_valid", 32'(m_valid), 32'd1);
    check_val("full_m_ready", 32'(m_ready), 32'd0);
    check_val("full_l_ready", 32'(l_ready), 32'd0);
    ser_in = 1'b1; ser_valid = 1'b1;
    @(negedge clk);
    ser_valid = 1'b0;
    check_val("stall_m_out", 32'(m_out), 32'h3C);
    check_val("stall_m_cnt", 32'(m_cnt), 32'd0);
    par_ready = 1'b1;
    @(negedge clk);
    par_ready = 1'b0;
    check_val("pop_m_out",   32'(m_out),   32'h81);
    check_val("pop_m_valid", 32'(m_valid), 32'd1);
    check_val("pop_m_ready", 32'(m_ready), 32'd1);
    check_val("pop_l_out",   32'(l_out),   32'h81);
    par_ready = 1'b1;
    @(negedge clk);
    check_val("pop2_m_valid", 32'(m_valid), 32'd0);

    // clr after 3 bits drops the partial word and the bit offered with it
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    check_val("pre_clr_cnt", 32'(m_cnt), 32'd3);
    clr = 1'b1; ser_in = 1'b1; ser_valid = 1'b1;
    @(negedge clk);
    clr = 1'b0; ser_valid = 1'b0;
    check_val("clr_m_cnt",   32'(m_cnt),   32'd0);
    check_val("clr_m_valid", 32'(m_valid), 32'd0);
    send_word(8'h5A);
    check_val("5a_m_out", 32'(m_out), 32'h5A);
    check_val("5a_l_out", 32'(l_out), 32'h5A);
    @(negedge clk);

    // clr while FULL drops the held word; output register untouched
    par_ready = 1'b0;
    send_word(8'h3C);
    send_word(8'h81);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check_val("clrf_m_ready", 32'(m_ready), 32'd1);
    check_val("clrf_m_out",   32'(m_out),   32'h3C);
    check_val("clrf_m_valid", 32'(m_valid), 32'd1);
    par_ready = 1'b1;
    @(negedge clk);
    par_ready = 1'b0;
    check_val("clrf_pop_valid", 32'(m_valid), 32'd0);
    check_val("clrf_pop_out",   32'(m_out),   32'h3C);

    // F0 then 0F with random input gaps; pop coincides with 0F completion
    for (int i = 7; i >= 0; i--) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send_bit(i >= 4);
    end
    check_val("f0_m_out",   32'(m_out),   32'hF0);
    check_val("f0_l_out",   32'(l_out),   32'h0F);
    check_val("f0_m_valid", 32'(m_valid), 32'd1);
    for (int i = 7; i >= 1; i--) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        check_val("gap_m_valid", 32'(m_valid), 32'd1);
      end
      send_bit(i < 4);
      check_val("hold_m_out", 32'(m_out), 32'hF0);
    end
    par_ready = 1'b1;
    send_bit(1'b1);
    check_val("0f_m_out",   32'(m_out),   32'h0F);
    check_val("0f_l_out",   32'(l_out),   32'hF0);
    check_val("0f_m_valid", 32'(m_valid), 32'd1);
    @(negedge clk);
    check_val("0f_m_drop",  32'(m_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
